// File: rtl/mem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache for 16-bit CPU word accesses.
// Read misses refill a whole line from Memory one word per cycle; writes always go to Memory.
//
// state  | meaning
// IDLE   | waiting for a request; a flush clears every valid bit
// LOOKUP | compare tag, count hit/miss, pick the next step
// REFILL | fetch line words 0..LINE_WORDS-1 from Memory
// WRITE  | single Memory write cycle, update the line on a hit, write done pulse
// RESP   | read completion pulse
module mem_cache_ctrl #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_flush,
  output logic        cpu_ready,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_wdone,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_out,
  output logic        mem_write_en,
  input  logic [15:0] mem_data_in,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 15 - OFF_W - IDX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  logic [2:0]           state_q, state_d;
  logic [14:0]          addr_q;
  logic                 we_q;
  logic [15:0]          wdata_q;
  logic                 hit_q;
  logic [OFF_W-1:0]     cnt_q;
  logic [15:0]          rdata_q;
  logic [15:0]          hit_cnt_q;
  logic [15:0]          miss_cnt_q;
  logic [NUM_LINES-1:0] valid_q;

  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [15:0]          data_mem [NUM_LINES][LINE_WORDS];

  logic [OFF_W-1:0]     off;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic                 lookup_hit;
  logic                 accept;
  logic                 unused_addr_bit;

  // byte-address bit 0 has no meaning for word accesses
  assign unused_addr_bit = cpu_addr[0];

  assign off        = addr_q[OFF_W-1:0];
  assign idx        = addr_q[OFF_W +: IDX_W];
  assign tag        = addr_q[14 -: TAG_W];
  assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);
  assign accept     = (state_q == S_IDLE) && cpu_req && !cpu_flush;

  // next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (we_q)            state_d = S_WRITE;
        else if (lookup_hit) state_d = S_RESP;
        else                 state_d = S_REFILL;
      end
      S_REFILL: if (cnt_q == LAST_WORD) state_d = S_RESP;
      S_WRITE:  state_d = S_IDLE;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // control registers, valid bits, read data and statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      hit_q      <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (cpu_flush) begin
            valid_q <= '0;
          end else if (cpu_req) begin
            addr_q  <= cpu_addr[15:1];
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
          end
        end
        S_LOOKUP: begin
          hit_q <= lookup_hit;
          cnt_q <= '0;
          if (lookup_hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (!we_q) rdata_q <= data_mem[idx][off];
          end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
          end
        end
        S_REFILL: begin
          if (cnt_q == off) rdata_q <= mem_data_in;
          cnt_q <= cnt_q + OFF_W'(1);
          // the line only becomes usable once its last word is in place
          if (cnt_q == LAST_WORD) valid_q[idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // tag and data storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL) begin
      data_mem[idx][cnt_q] <= mem_data_in;
      if (cnt_q == LAST_WORD) tag_mem[idx] <= tag;
    end
    if ((state_q == S_WRITE) && hit_q) data_mem[idx][off] <= wdata_q;
  end

  // Memory-side address/data, all zero outside REFILL and WRITE
  always_comb begin
    mem_address  = '0;
    mem_data_out = '0;
    mem_write_en = 1'b0;
    if (state_q == S_REFILL) begin
      mem_address = {addr_q[14:OFF_W], cnt_q, 1'b0};
    end else if (state_q == S_WRITE) begin
      mem_address  = {addr_q, 1'b0};
      mem_data_out = wdata_q;
      mem_write_en = 1'b1;
    end
  end

  assign cpu_ready  = (state_q == S_IDLE) && !cpu_flush;
  assign cpu_rvalid = (state_q == S_RESP);
  assign cpu_wdone  = (state_q == S_WRITE);
  assign cpu_rdata  = rdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule
